i2c_target: RTL

//  I2C target (slave) end of the bridge's I2C link; the peer that i2c_master addresses on SDA/SCL.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_in_sync.sv | 78 +++++++
 rtl/i2c_target.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_WR_DATA,
    ST_DATA_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_in_sync.sv
// Pin conditioner: 2-flop sync, optional stability filter (I2C_TGT_GLITCH_FILTER_EN),
// then an edge register producing level plus one-cycle rise/fall pulses.
module i2c_in_sync #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;
  logic r_rise;
  logic r_fall;
  logic w_level;

  // Idle bus is high, so the sync chain resets to 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  // Accept a new level only after FILTER_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else if (r_s2 == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
      r_filt <= r_s2;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign w_level = r_filt;
`else
  // FILTER_CYCLES has no effect without the filter.
  if (FILTER_CYCLES == 0) begin : g_filter_unused
  end

  assign w_level = r_s2;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a byte-addressed register window (write strobe + read lookup).
// Optional SCL/SDA glitch filter enabled by defining I2C_TGT_GLITCH_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR   = 7'h50,
  parameter int unsigned NUM_REGS      = 16,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        SCL_I,
  input  logic                        SDA_I,
  output logic                        SDA_OE,
  output logic                        WR_STROBE,
  output logic [$clog2(NUM_REGS)-1:0] WR_ADDR,
  output logic [7:0]                  WR_DATA,
  output logic [$clog2(NUM_REGS)-1:0] RD_ADDR,
  input  logic [7:0]                  RD_DATA,
  output logic                        BUSY
);

  localparam int unsigned PW = $clog2(NUM_REGS);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_addr_match, w_ptr_ok;
  logic [7:0] w_rx_byte;

  i2c_tgt_state_t r_state, w_state_nxt;

  logic          r_sda_oe, w_oe_nxt;
  logic          r_wr_strobe, w_strobe_nxt;
  logic [PW-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]    r_wr_data, w_wr_data_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [3:0]    r_bitcnt, w_cnt_nxt;
  logic          r_busy, w_busy_nxt;

  i2c_in_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_sync (
    .i_clk(ACLK), .i_rst_n(ARESETn), .i_pin(SCL_I),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_in_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_sync (
    .i_clk(ACLK), .i_rst_n(ARESETn), .i_pin(SDA_I),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start      = w_sda_fall & w_scl;
  assign w_stop       = w_sda_rise & w_scl;
  assign w_rx_byte    = {r_shift[6:0], w_sda};
  assign w_addr_match = (r_shift[7:1] == TARGET_ADDR);
  assign w_ptr_ok     = ({1'b0, r_shift} < 9'(NUM_REGS));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Bus conditions override everything; otherwise advance on SCL edges.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR:     if (w_scl_fall && r_bitcnt == 4'd8)
                       w_state_nxt = w_addr_match ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK: if (w_scl_fall)
                       w_state_nxt = (r_shift[0] == I2C_RW_READ) ? ST_RD_DATA : ST_PTR;
        ST_PTR:      if (w_scl_fall && r_bitcnt == 4'd8)
                       w_state_nxt = w_ptr_ok ? ST_DATA_ACK : ST_IGNORE;
        ST_WR_DATA:  if (w_scl_fall && r_bitcnt == 4'd8) w_state_nxt = ST_DATA_ACK;
        ST_DATA_ACK: if (w_scl_fall) w_state_nxt = ST_WR_DATA;
        ST_RD_DATA:  if (w_scl_fall && r_bitcnt == 4'd8) w_state_nxt = ST_RD_ACK;
        ST_RD_ACK: begin
          if (w_scl_rise && w_sda == I2C_NACK) w_state_nxt = ST_IGNORE;
          else if (w_scl_fall)                 w_state_nxt = ST_RD_DATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_oe_nxt      = r_sda_oe;
    w_strobe_nxt  = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_ptr_nxt     = r_ptr;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_bitcnt;
    w_busy_nxt    = r_busy;
    if (w_start) begin
      w_oe_nxt   = 1'b0;
      w_cnt_nxt  = 4'd0;
      w_busy_nxt = 1'b1;
    end else if (w_stop) begin
      w_oe_nxt   = 1'b0;
      w_busy_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (w_scl_rise && r_bitcnt != 4'd8) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = r_bitcnt + 4'd1;
            if (r_state == ST_WR_DATA && r_bitcnt == 4'd7) begin
              w_strobe_nxt  = 1'b1;
              w_wr_addr_nxt = r_ptr;
              w_wr_data_nxt = w_rx_byte;
              w_ptr_nxt     = r_ptr + PW'(1);
            end
          end
          if (w_scl_fall && r_bitcnt == 4'd8) begin
            if (r_state == ST_ADDR) begin
              w_oe_nxt = w_addr_match;
            end else if (r_state == ST_PTR) begin
              if (w_ptr_ok) begin
                w_ptr_nxt = PW'(r_shift);
                w_oe_nxt  = 1'b1;
              end
            end else begin
              w_oe_nxt = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: if (w_scl_fall) begin
          w_oe_nxt  = 1'b0;
          w_cnt_nxt = 4'd0;
          if (r_shift[0] == I2C_RW_READ) begin
            w_shift_nxt = RD_DATA;
            w_oe_nxt    = ~RD_DATA[7];
            w_cnt_nxt   = 4'd1;
          end
        end
        ST_DATA_ACK: if (w_scl_fall) begin
          w_oe_nxt  = 1'b0;
          w_cnt_nxt = 4'd0;
        end
        // r_bitcnt counts bits already placed on the bus.
        ST_RD_DATA: if (w_scl_fall) begin
          if (r_bitcnt == 4'd8) begin
            w_oe_nxt = 1'b0;
          end else begin
            w_oe_nxt    = ~r_shift[6];
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_cnt_nxt   = r_bitcnt + 4'd1;
          end
        end
        ST_RD_ACK: begin
          if (w_scl_rise && w_sda == I2C_ACK) w_ptr_nxt = r_ptr + PW'(1);
          if (w_scl_fall) begin
            w_shift_nxt = RD_DATA;
            w_oe_nxt    = ~RD_DATA[7];
            w_cnt_nxt   = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_sda_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_ptr       <= '0;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_sda_oe    <= w_oe_nxt;
      r_wr_strobe <= w_strobe_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_ptr       <= w_ptr_nxt;
      r_shift     <= w_shift_nxt;
      r_bitcnt    <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign SDA_OE    = r_sda_oe;
  assign WR_STROBE = r_wr_strobe;
  assign WR_ADDR   = r_wr_addr;
  assign WR_DATA   = r_wr_data;
  assign RD_ADDR   = r_ptr;
  assign BUSY      = r_busy;

endmodule
